// File: rtl/uart_reg_bridge_if.sv
// Byte-FIFO and register-bus bundle between uart_reg_bridge (master) and the
// UART FIFOs / control registers (slave).
interface uart_reg_bridge_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);
  logic                 RxEmpty;
  logic [DATA_BITS-1:0] ReadData;
  logic                 ReadUart;
  logic                 TxFull;
  logic [DATA_BITS-1:0] WriteData;
  logic                 WriteUart;
  logic [ADDR_BITS-1:0] RegAddr;
  logic [DATA_BITS-1:0] RegWData;
  logic                 RegWrite;
  logic                 RegRead;
  logic [DATA_BITS-1:0] RegRData;

  modport master (
    input  RxEmpty, ReadData, TxFull, RegRData,
    output ReadUart, WriteData, WriteUart, RegAddr, RegWData, RegWrite, RegRead
  );

  modport slave (
    output RxEmpty, ReadData, TxFull, RegRData,
    input  ReadUart, WriteData, WriteUart, RegAddr, RegWData, RegWrite, RegRead
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// UART command responder: 'W' addr data / 'R' addr frames drive a register bus, one response byte per frame.
// Optional trailing XOR checksum byte per frame when UART_BRIDGE_CHECKSUM_EN is defined.
module uart_reg_bridge #(
  parameter int DATA_BITS      = 8,
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 2600000
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  uart_reg_bridge_if.master    bus,
  output logic                 Busy,
  output logic [7:0]           ErrCount
);

  localparam logic [DATA_BITS-1:0] CMD_WRITE = DATA_BITS'(8'h57);
  localparam logic [DATA_BITS-1:0] CMD_READ  = DATA_BITS'(8'h52);
  localparam logic [DATA_BITS-1:0] RESP_ACK  = DATA_BITS'(8'h06);
  localparam logic [DATA_BITS-1:0] RESP_NAK  = DATA_BITS'(8'h15);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
    S_GET_CSUM,
`endif
    S_EXEC,
    S_READ_WAIT,
    S_SEND
  } state_t;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam state_t FRAME_DONE = S_GET_CSUM;
`else
  localparam state_t FRAME_DONE = S_EXEC;
`endif

  state_t               state_q, state_d;
  logic                 isWrite_q, isWrite_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] resp_q, resp_d;
  logic [7:0]           err_q, err_d;
  logic [TO_W-1:0]      tocnt_q, tocnt_d;
  logic                 popped_q;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [DATA_BITS-1:0] csum_q, csum_d;
`endif

  logic                 inGet;
  logic                 pop;
  logic                 timeout;
  logic                 errInc;
  logic [DATA_BITS-1:0] rxByte;

  assign rxByte = bus.ReadData;

  always_comb begin
    inGet = 1'b0;
    case (state_q)
      S_GET_ADDR,
`ifdef UART_BRIDGE_CHECKSUM_EN
      S_GET_CSUM,
`endif
      S_GET_DATA: inGet = 1'b1;
      default:    inGet = 1'b0;
    endcase
  end

  // At most one pop every other cycle so the FIFO empty flag has time to settle.
  assign pop     = ((state_q == S_IDLE) || inGet) && !bus.RxEmpty && !popped_q;
  assign timeout = inGet && !pop && (tocnt_q == TO_LAST);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      isWrite_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      err_q     <= '0;
      tocnt_q   <= '0;
      // Treated as a recent pop so nothing is popped while reset is held.
      popped_q  <= 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      isWrite_q <= isWrite_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      tocnt_q   <= tocnt_d;
      popped_q  <= pop;
`ifdef UART_BRIDGE_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    isWrite_d = isWrite_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
    tocnt_d   = '0;
    errInc    = 1'b0;
`ifdef UART_BRIDGE_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (inGet && !pop && !timeout) begin
      tocnt_d = tocnt_q + TO_W'(1);
    end

    if (timeout) begin
      state_d = S_IDLE;
      errInc  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum_d = rxByte;
`endif
            if (rxByte == CMD_WRITE) begin
              isWrite_d = 1'b1;
              state_d   = S_GET_ADDR;
            end else if (rxByte == CMD_READ) begin
              isWrite_d = 1'b0;
              state_d   = S_GET_ADDR;
            end else begin
              resp_d  = RESP_NAK;
              errInc  = 1'b1;
              state_d = S_SEND;
            end
          end
        end

        S_GET_ADDR: begin
          if (pop) begin
            addr_d = rxByte[ADDR_BITS-1:0];
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum_d = csum_q ^ rxByte;
`endif
            state_d = isWrite_q ? S_GET_DATA : FRAME_DONE;
          end
        end

        S_GET_DATA: begin
          if (pop) begin
            wdata_d = rxByte;
`ifdef UART_BRIDGE_CHECKSUM_EN
            csum_d = csum_q ^ rxByte;
`endif
            state_d = FRAME_DONE;
          end
        end

`ifdef UART_BRIDGE_CHECKSUM_EN
        S_GET_CSUM: begin
          if (pop) begin
            if (rxByte == csum_q) begin
              state_d = S_EXEC;
            end else begin
              resp_d  = RESP_NAK;
              errInc  = 1'b1;
              state_d = S_SEND;
            end
          end
        end
`endif

        S_EXEC: begin
          if (isWrite_q) begin
            resp_d  = RESP_ACK;
            state_d = S_SEND;
          end else begin
            state_d = S_READ_WAIT;
          end
        end

        S_READ_WAIT: begin
          resp_d  = bus.RegRData;
          state_d = S_SEND;
        end

        S_SEND: begin
          if (!bus.TxFull) begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (errInc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign bus.ReadUart  = pop;
  assign bus.WriteUart = (state_q == S_SEND) && !bus.TxFull;
  assign bus.WriteData = resp_q;
  assign bus.RegAddr   = addr_q;
  assign bus.RegWData  = wdata_q;
  assign bus.RegWrite  = (state_q == S_EXEC) && isWrite_q;
  assign bus.RegRead   = (state_q == S_EXEC) && !isWrite_q;
  assign Busy          = (state_q != S_IDLE);
  assign ErrCount      = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: vector table of frames plus timeout, TxFull back-pressure and reset sequences.
module tb_uart_reg_bridge;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       Busy;
  logic [7:0] ErrCount;

  always #5 Clock = ~Clock;

  uart_reg_bridge_if #(.DATA_BITS(8), .ADDR_BITS(8)) u_if ();

  uart_reg_bridge #(
    .DATA_BITS(8),
    .ADDR_BITS(8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .bus(u_if.master),
    .Busy(Busy),
    .ErrCount(ErrCount)
  );

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    logic [7:0] rdata;
    bit         isWr;
    bit         isRd;
    logic [7:0] expResp;
    int         expErrInc;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxMem [0:255];
  int         rxWr = 0;
  int         rxRd = 0;
  logic [7:0] regValue = 8'h00;

  int         cyc = 0;
  int         txCount = 0, wrCount = 0, rdCount = 0;
  int         lastPopCyc = 0, wrCyc = 0, rdCyc = 0, txCyc = 0;
  logic [7:0] lastTx = 8'h00;
  bit         popReq = 1'b0, rdReq = 1'b0;

  int         errExp = 0;
  logic [7:0] expAddr = 8'h00, expWData = 8'h00;

  // Monitor: everything the DUT does on the active edge, stamped with a cycle number.
  always @(posedge Clock) begin
    popReq = u_if.ReadUart;
    rdReq  = u_if.RegRead;
    if (u_if.ReadUart) lastPopCyc = cyc;
    if (u_if.RegWrite) begin
      wrCount++;
      wrCyc = cyc;
    end
    if (u_if.RegRead) begin
      rdCount++;
      rdCyc = cyc;
    end
    if (u_if.WriteUart) begin
      txCount++;
      txCyc  = cyc;
      lastTx = u_if.WriteData;
    end
    cyc++;
  end

  // Receive FIFO and register-file responder, updated half a cycle after the DUT edge.
  always @(negedge Clock) begin
    if (ResetN !== 1'b1) rxRd = rxWr;
    else if (popReq && (rxRd != rxWr)) rxRd++;
    u_if.RxEmpty  = (rxRd == rxWr);
    u_if.ReadData = (rxRd == rxWr) ? 8'h00 : rxMem[rxRd % 256];
    if (rdReq) u_if.RegRData = regValue;
    else if (cyc < 2) u_if.RegRData = 8'h00;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    rxMem[rxWr % 256] = b;
    rxWr++;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] cs;
    cs = v.b0;
    pushByte(v.b0);
    if (v.n > 1) begin
      pushByte(v.b1);
      cs = cs ^ v.b1;
    end
    if (v.n > 2) begin
      pushByte(v.b2);
      cs = cs ^ v.b2;
    end
`ifdef UART_BRIDGE_CHECKSUM_EN
    if (v.isWr || v.isRd) pushByte(cs);
`endif
  endtask

  task automatic waitTx(input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (txCount > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int tx0, wr0, rd0;
    bit ok;
    tx0 = txCount;
    wr0 = wrCount;
    rd0 = rdCount;
    regValue = v.rdata;
    errExp += v.expErrInc;
    applyStimulus(v);
    waitTx(tx0, ok);
    checkOutput({tag, " tx_seen"}, 32'(ok), 32'd1);
    repeat (3) @(negedge Clock);
    checkOutput({tag, " resp"}, 32'(lastTx), 32'(v.expResp));
    checkOutput({tag, " tx_pulses"}, 32'(txCount - tx0), 32'd1);
    checkOutput({tag, " reg_writes"}, 32'(wrCount - wr0), 32'(v.isWr));
    checkOutput({tag, " reg_reads"}, 32'(rdCount - rd0), 32'(v.isRd));
    checkOutput({tag, " err_count"}, 32'(ErrCount), 32'(errExp));
    checkOutput({tag, " busy_low"}, 32'(Busy), 32'd0);
    if (v.isWr) begin
      expAddr  = v.b1;
      expWData = v.b2;
      checkOutput({tag, " wr_strobe_cycle"}, 32'(wrCyc), 32'(lastPopCyc + 1));
      checkOutput({tag, " wr_tx_cycle"}, 32'(txCyc), 32'(lastPopCyc + 2));
    end
    if (v.isRd) begin
      expAddr = v.b1;
      checkOutput({tag, " rd_strobe_cycle"}, 32'(rdCyc), 32'(lastPopCyc + 1));
      checkOutput({tag, " rd_tx_cycle"}, 32'(txCyc), 32'(lastPopCyc + 3));
    end
    checkOutput({tag, " reg_addr"}, 32'(u_if.RegAddr), 32'(expAddr));
    checkOutput({tag, " reg_wdata"}, 32'(u_if.RegWData), 32'(expWData));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ReadUart"}, 32'(u_if.ReadUart), 32'd0);
    checkOutput({tag, " WriteUart"}, 32'(u_if.WriteUart), 32'd0);
    checkOutput({tag, " RegWrite"}, 32'(u_if.RegWrite), 32'd0);
    checkOutput({tag, " RegRead"}, 32'(u_if.RegRead), 32'd0);
    checkOutput({tag, " Busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, " WriteData"}, 32'(u_if.WriteData), 32'd0);
    checkOutput({tag, " RegAddr"}, 32'(u_if.RegAddr), 32'd0);
    checkOutput({tag, " RegWData"}, 32'(u_if.RegWData), 32'd0);
    checkOutput({tag, " ErrCount"}, 32'(ErrCount), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int tx0, rd0, wr0, dropCyc;
    bit ok;

    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 8'h00, 1'b1, 1'b0, 8'h06, 0};
    vecs[1] = '{8'h52, 8'h10, 8'h00, 2, 8'h3C, 1'b0, 1'b1, 8'h3C, 0};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h15, 1};
    vecs[3] = '{8'h57, 8'hFF, 8'h00, 3, 8'h00, 1'b1, 1'b0, 8'h06, 0};
    vecs[4] = '{8'h52, 8'hFF, 8'h00, 2, 8'hC3, 1'b0, 1'b1, 8'hC3, 0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 1'b0, 1'b0, 8'h15, 1};

    ResetN = 1'b0;
    u_if.TxFull = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    checkResetOutputs("por");
    @(negedge Clock);
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);

    for (int i = 0; i < 6; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Abandoned write frame: counter must expire, count an error, and stay silent.
    tx0 = txCount;
    wr0 = wrCount;
    errExp++;
    pushByte(8'h57);
    pushByte(8'h10);
    repeat (60) @(negedge Clock);
    checkOutput("timeout busy_mid", 32'(Busy), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (!Busy) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("timeout busy_fell", 32'(ok), 32'd1);
    checkOutput("timeout err_count", 32'(ErrCount), 32'(errExp));
    checkOutput("timeout no_tx", 32'(txCount - tx0), 32'd0);
    checkOutput("timeout no_write", 32'(wrCount - wr0), 32'd0);
    runVector("post_timeout", '{8'h57, 8'h20, 8'h5A, 3, 8'h00, 1'b1, 1'b0, 8'h06, 0});

    // Response held back by a full transmit FIFO.
    u_if.TxFull = 1'b1;
    tx0 = txCount;
    rd0 = rdCount;
    regValue = 8'h9E;
    applyStimulus('{8'h52, 8'h33, 8'h00, 2, 8'h9E, 1'b0, 1'b1, 8'h9E, 0});
    repeat (50) @(negedge Clock);
    checkOutput("txfull no_tx", 32'(txCount - tx0), 32'd0);
    checkOutput("txfull busy", 32'(Busy), 32'd1);
    checkOutput("txfull one_read", 32'(rdCount - rd0), 32'd1);
    dropCyc = cyc;
    u_if.TxFull = 1'b0;
    @(negedge Clock);
    checkOutput("txfull tx_once", 32'(txCount - tx0), 32'd1);
    checkOutput("txfull tx_cycle", 32'(txCyc), 32'(dropCyc));
    checkOutput("txfull resp", 32'(lastTx), 32'h9E);
    repeat (3) @(negedge Clock);
    checkOutput("txfull tx_still_once", 32'(txCount - tx0), 32'd1);
    checkOutput("txfull busy_low", 32'(Busy), 32'd0);
    expAddr = 8'h33;

`ifdef UART_BRIDGE_CHECKSUM_EN
    tx0 = txCount;
    wr0 = wrCount;
    errExp++;
    pushByte(8'h57);
    pushByte(8'h10);
    pushByte(8'hA5);
    pushByte(8'h00);
    waitTx(tx0, ok);
    checkOutput("csum tx_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge Clock);
    checkOutput("csum resp", 32'(lastTx), 32'h15);
    checkOutput("csum no_write", 32'(wrCount - wr0), 32'd0);
    checkOutput("csum err_count", 32'(ErrCount), 32'(errExp));
    expAddr = 8'h10;
`endif

    // Reset in the middle of a write frame.
    pushByte(8'h57);
    pushByte(8'h10);
    repeat (8) @(negedge Clock);
    checkOutput("midreset busy_before", 32'(Busy), 32'd1);
    checkOutput("midreset addr_before", 32'(u_if.RegAddr), 32'h10);
    ResetN = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    errExp   = 0;
    expAddr  = 8'h00;
    expWData = 8'h00;
    repeat (2) @(negedge Clock);
    runVector("post_reset", '{8'h52, 8'h44, 8'h00, 2, 8'h7B, 1'b0, 1'b1, 8'h7B, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
